// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 device-side emulator: start-pulse detect, preamble and 40-bit frame
module dht11_responder #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int START_MIN_US = 18000,
    parameter int WAIT_US      = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int ZERO_HIGH_US = 26,
    parameter int ONE_HIGH_US  = 70
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_i,
    output logic       data_drive_low,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       corrupt_chk,
    output logic       busy,
    output logic       frame_done
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam int UW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_WAIT, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    state_t          state, state_nx;
    logic            sync1, ds;
    logic [PW-1:0]   pre;
    logic [UW-1:0]   us_cnt;
    logic [UW-1:0]   dur;
    logic [39:0]     frame;
    logic [5:0]      idx;
    logic [9:0]      sum;
    logic [7:0]      chk;
    logic            tick, done, start_ok, capture, drive_nx, busy_nx;

    assign tick = (pre == PW'(CLK_FREQ_MHZ - 1));
    assign sum  = {2'b00, hum_int} + {2'b00, hum_dec} + {2'b00, temp_int} + {2'b00, temp_dec};
    assign chk  = sum[7:0] ^ {8{corrupt_chk}};

    // The current microsecond counts once its last prescaler cycle is reached, so a
    // line low for exactly START_MIN_US is accepted.
    assign start_ok = (us_cnt >= UW'(START_MIN_US)) ||
                      (tick && (us_cnt == UW'(START_MIN_US - 1)));

    always_comb begin
        dur = UW'(1);
        case (state)
            S_WAIT:      dur = UW'(WAIT_US);
            S_RESP_LOW:  dur = UW'(RESP_LOW_US);
            S_RESP_HIGH: dur = UW'(RESP_HIGH_US);
            S_BIT_LOW:   dur = UW'(BIT_LOW_US);
            S_BIT_HIGH:  dur = frame[idx] ? UW'(ONE_HIGH_US) : UW'(ZERO_HIGH_US);
            S_END_LOW:   dur = UW'(BIT_LOW_US);
            default:     dur = UW'(1);
        endcase
    end

    assign done = tick && (us_cnt == dur - UW'(1));

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            S_IDLE:      if (!ds) state_nx = S_HOST_LOW;
            S_HOST_LOW:  if (ds) begin
                             capture  = start_ok;
                             state_nx = start_ok ? S_WAIT : S_IDLE;
                         end
            S_WAIT:      if (done) state_nx = S_RESP_LOW;
            S_RESP_LOW:  if (done) state_nx = S_RESP_HIGH;
            S_RESP_HIGH: if (done) state_nx = S_BIT_LOW;
            S_BIT_LOW:   if (done) state_nx = S_BIT_HIGH;
            S_BIT_HIGH:  if (done) state_nx = (idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
            S_END_LOW:   if (done) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
        drive_nx = (state_nx == S_RESP_LOW) || (state_nx == S_BIT_LOW) || (state_nx == S_END_LOW);
        busy_nx  = (state_nx != S_IDLE) && (state_nx != S_HOST_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1          <= 1'b1;
            ds             <= 1'b1;
            state          <= S_IDLE;
            pre            <= '0;
            us_cnt         <= '0;
            frame          <= '0;
            idx            <= '0;
            data_drive_low <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            sync1 <= data_i;
            ds    <= sync1;
            state <= state_nx;
            // Every transition restarts the timer; the microsecond count saturates.
            if (state_nx != state) begin
                pre    <= '0;
                us_cnt <= '0;
            end else if (tick) begin
                pre <= '0;
                if (us_cnt != '1) us_cnt <= us_cnt + UW'(1);
            end else begin
                pre <= pre + PW'(1);
            end
            if (capture) frame <= {hum_int, hum_dec, temp_int, temp_dec, chk};
            if (state == S_RESP_HIGH && done)
                idx <= 6'd39;
            else if (state == S_BIT_HIGH && done && idx != 6'd0)
                idx <= idx - 6'd1;
            data_drive_low <= drive_nx;
            busy           <= busy_nx;
            frame_done     <= (state == S_END_LOW) && done;
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - randomized self-checking bench for dht11_responder
module tb_dht11_responder;

    localparam int CLK  = 2;
    localparam int SMIN = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_low;
    logic       data_i;
    logic       data_drive_low;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       corrupt_chk;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int segs[$];
    int exp_segs[$];
    int lat;
    int ndone;
    logic fd_after, busy_after, busy_first;

    always #5 clk = ~clk;

    // Open-drain wire with pull-up: low if either side pulls it.
    assign data_i = ~(host_low | data_drive_low);

    dht11_responder #(
        .CLK_FREQ_MHZ(CLK),
        .START_MIN_US(SMIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_i(data_i),
        .data_drive_low(data_drive_low),
        .hum_int(hum_int),
        .hum_dec(hum_dec),
        .temp_int(temp_int),
        .temp_dec(temp_dec),
        .corrupt_chk(corrupt_chk),
        .busy(busy),
        .frame_done(frame_done)
    );

    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input logic corrupt);
        int s;
        logic [7:0] k;
        s = int'(a) + int'(b) + int'(c) + int'(d);
        k = 8'(s % 256);
        if (corrupt) k = ~k;
        return {a, b, c, d, k};
    endfunction

    // Expected run lengths (cycles) of alternating low/high driven segments.
    task automatic build_exp(input logic [39:0] f);
        exp_segs.delete();
        exp_segs.push_back(80 * CLK);
        exp_segs.push_back(80 * CLK);
        for (int i = 39; i >= 0; i--) begin
            exp_segs.push_back(50 * CLK);
            exp_segs.push_back((f[i] ? 70 : 26) * CLK);
        end
        exp_segs.push_back(50 * CLK);
    endtask

    function automatic int seg_diffs();
        int n = 0;
        if (segs.size() != exp_segs.size()) return 1000 + segs.size();
        foreach (segs[i]) if (segs[i] != exp_segs[i]) n++;
        return n;
    endfunction

    function automatic logic [39:0] decode();
        logic [39:0] d = '0;
        if (segs.size() < 83) return '0;
        for (int i = 0; i < 40; i++) d[39-i] = (segs[3+2*i] > 48 * CLK);
        return d;
    endfunction

    task automatic host_start(input int us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (us * CLK) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Called right after host release: records latency and driven run lengths.
    task automatic capture();
        int   k = 0;
        int   run = 1;
        int   t = 0;
        logic lvl = 1'b1;
        segs.delete();
        ndone = 0;
        busy_first = 1'b0;
        fd_after = 1'bx;
        busy_after = 1'bx;
        while (!data_drive_low && k < 200 * CLK) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        if (!data_drive_low) return;
        busy_first = busy;
        while (t < 9000 * CLK) begin
            @(negedge clk);
            t++;
            if (frame_done) begin
                segs.push_back(run);
                ndone++;
                break;
            end
            if (data_drive_low == lvl) run++;
            else begin
                segs.push_back(run);
                lvl = data_drive_low;
                run = 1;
            end
        end
        @(negedge clk);
        fd_after = frame_done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        host_low = 1'b0;
        corrupt_chk = 1'b0;
        {hum_int, hum_dec, temp_int, temp_dec} = 32'h0;
        repeat (5) @(negedge clk);
        total++;
        if ({data_drive_low, busy, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000", {data_drive_low, busy, frame_done});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({data_drive_low, busy} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want 00", {data_drive_low, busy});
        end
    endtask

    task automatic test_valid_frame();
        logic [39:0] exp;
        {hum_int, hum_dec, temp_int, temp_dec} = 32'h37001900;
        corrupt_chk = 1'b0;
        exp = model_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
        build_exp(exp);
        host_start(250);
        capture();
        total++;
        if (lat < 2 + 30 * CLK - 1 || lat > 2 + 30 * CLK + 1) begin
            bad++;
            $display("FAIL valid_latency: got %0d want %0d+-1", lat, 2 + 30 * CLK);
        end
        total++;
        if (busy_first !== 1'b1) begin
            bad++;
            $display("FAIL valid_busy: got %b want 1", busy_first);
        end
        total++;
        if (decode() !== 40'h3700190050) begin
            bad++;
            $display("FAIL valid_data: got %h want 3700190050", decode());
        end
        total++;
        if (seg_diffs() !== 0) begin
            bad++;
            $display("FAIL valid_timing: got %0d bad segments want 0", seg_diffs());
        end
        total++;
        if (ndone !== 1 || fd_after !== 1'b0 || busy_after !== 1'b0) begin
            bad++;
            $display("FAIL valid_done: got pulses=%0d after=%b busy=%b want 1 0 0", ndone, fd_after, busy_after);
        end
    endtask

    task automatic test_bit_timing();
        int want[8] = '{70, 26, 70, 26, 26, 70, 26, 70};
        logic [39:0] exp;
        int nbad = 0;
        hum_int = 8'hA5;
        hum_dec = 8'($urandom);
        temp_int = 8'($urandom);
        temp_dec = 8'($urandom);
        exp = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b0);
        build_exp(exp);
        host_start(SMIN);
        capture();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (segs.size() < 83 || segs[3+2*i] !== want[i] * CLK) begin
                bad++;
                $display("FAIL bit_high_%0d: got %0d want %0d", i,
                         (segs.size() > 3 + 2 * i) ? segs[3+2*i] : -1, want[i] * CLK);
            end
        end
        for (int i = 0; i < 41; i++)
            if (segs.size() < 83 || segs[2+2*i] != 50 * CLK) nbad++;
        total++;
        if (nbad !== 0) begin
            bad++;
            $display("FAIL bit_lows: got %0d wrong want 0", nbad);
        end
        total++;
        if (decode() !== exp || seg_diffs() !== 0) begin
            bad++;
            $display("FAIL bit_frame: got %h want %h", decode(), exp);
        end
    endtask

    task automatic test_glitch_and_checksum();
        logic seen = 1'b0;
        logic [39:0] exp;
        {hum_int, hum_dec, temp_int, temp_dec} = 32'hFFFF0102;
        corrupt_chk = 1'b0;
        host_start(SMIN - 1);
        repeat (400 * CLK) begin
            @(negedge clk);
            if (data_drive_low || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_reject: got activity=%b want 0", seen);
        end
        exp = model_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
        build_exp(exp);
        host_start(SMIN);
        capture();
        total++;
        if (decode() !== exp || seg_diffs() !== 0 || ndone !== 1) begin
            bad++;
            $display("FAIL chk_wrap: got %h want %h", decode(), exp);
        end
        total++;
        if (decode()[7:0] !== 8'h01) begin
            bad++;
            $display("FAIL chk_wrap_byte: got %h want 01", decode()[7:0]);
        end
        corrupt_chk = 1'b1;
        exp = model_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1);
        build_exp(exp);
        host_start(250);
        capture();
        corrupt_chk = 1'b0;
        total++;
        if (decode() !== exp || seg_diffs() !== 0 || decode()[7:0] !== 8'hFE) begin
            bad++;
            $display("FAIL chk_corrupt: got %h want %h", decode(), exp);
        end
    endtask

    task automatic test_stability();
        logic [39:0] exp;
        hum_int = 8'h37;
        hum_dec = 8'($urandom);
        temp_int = 8'($urandom);
        temp_dec = 8'($urandom);
        exp = model_frame(8'h37, hum_dec, temp_int, temp_dec, 1'b0);
        build_exp(exp);
        host_start(250);
        fork
            capture();
            begin
                int w = 0;
                while (segs.size() < 22 && w < 20000) begin
                    @(negedge clk);
                    w++;
                end
                hum_int = 8'h40;
            end
        join
        total++;
        if (decode() !== exp || seg_diffs() !== 0) begin
            bad++;
            $display("FAIL stable_frame: got %h want %h", decode(), exp);
        end
        exp = model_frame(8'h40, hum_dec, temp_int, temp_dec, 1'b0);
        build_exp(exp);
        host_start(250);
        capture();
        total++;
        if (decode() !== exp || seg_diffs() !== 0) begin
            bad++;
            $display("FAIL stable_next: got %h want %h", decode(), exp);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] exp;
        int w = 0;
        logic seen = 1'b0;
        host_start(250);
        while (!data_drive_low && w < 200 * CLK) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({data_drive_low, busy} !== 2'b00) begin
            bad++;
            $display("FAIL midreset_outputs: got %b want 00", {data_drive_low, busy});
        end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (200 * CLK) begin
            @(negedge clk);
            if (data_drive_low || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: got activity=%b want 0", seen);
        end
        hum_int = 8'($urandom);
        hum_dec = 8'($urandom);
        temp_int = 8'($urandom);
        temp_dec = 8'($urandom);
        exp = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b0);
        build_exp(exp);
        host_start(250);
        capture();
        total++;
        if (decode() !== exp || seg_diffs() !== 0 || ndone !== 1) begin
            bad++;
            $display("FAIL midreset_frame: got %h want %h", decode(), exp);
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bit_timing();
        test_glitch_and_checksum();
        test_stability();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
